// File: rtl/mux_rr_param.sv
// N-lane round-robin TDM mux with valid/ack handshakes and output backpressure.
// Define MUX_RR_PARITY_EN to add an even-parity bit registered with data_out.
module mux_rr_param #(
    parameter  int WIDTH  = 4,
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]       valid_in,
    output logic [NUM_CH-1:0]       ack,
    input  logic                    skip_idle,
    input  logic                    ready_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    output logic [CH_W-1:0]         ch_out
`ifdef MUX_RR_PARITY_EN
    ,
    output logic                    parity_out
`endif
);

    logic [WIDTH-1:0] lane [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign lane[i] = data_in[i*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic             valid_q, valid_d;
`ifdef MUX_RR_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] cand;
    logic            found;
    logic            advance;
    logic            load;

    // Pointer wrap must work for non-power-of-two lane counts.
    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] p);
        if (p == CH_W'(NUM_CH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign advance = !valid_q || ready_in;

    always_comb begin
        cand  = ptr_q;
        sel   = ptr_q;
        found = 1'b0;
        if (skip_idle) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!found && valid_in[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
                cand = wrap_inc(cand);
            end
        end else begin
            found = valid_in[ptr_q];
        end
        // Strict mode loads even an idle lane, producing an empty slot.
        load = advance && (found || !skip_idle);
    end

    always_comb begin
        ack = '0;
        if (!reset && advance && found) begin
            ack[sel] = 1'b1;
        end
    end

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
`ifdef MUX_RR_PARITY_EN
        parity_d = parity_q;
`endif
        if (advance) begin
            valid_d = found;
            if (load) begin
                data_d = lane[sel];
                ch_d   = sel;
                ptr_d  = wrap_inc(sel);
`ifdef MUX_RR_PARITY_EN
                parity_d = ^lane[sel];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
`ifdef MUX_RR_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
`ifdef MUX_RR_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign ch_out    = ch_q;
    assign valid_out = valid_q;
`ifdef MUX_RR_PARITY_EN
    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_mux_rr_param.sv
// Directed bench for mux_rr_param: a 4-lane instance driven from a vector
// table plus hand sequences, and a 3-lane instance for pointer wrap.
module tb_mux_rr_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  ack;
    logic        skip_idle;
    logic        ready_in;
    logic [3:0]  data_out;
    logic        valid_out;
    logic [1:0]  ch_out;
`ifdef MUX_RR_PARITY_EN
    logic        parity_out;
    logic        parity3;
`endif

    logic        r3;
    logic [11:0] d3;
    logic [2:0]  v3;
    logic [2:0]  a3;
    logic        s3;
    logic        rdy3;
    logic [3:0]  do3;
    logic        vo3;
    logic [1:0]  co3;

    mux_rr_param #(.WIDTH(4), .NUM_CH(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ack       (ack),
        .skip_idle (skip_idle),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ch_out    (ch_out)
`ifdef MUX_RR_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    mux_rr_param #(.WIDTH(4), .NUM_CH(3)) u_dut3 (
        .clk       (clk),
        .reset     (r3),
        .data_in   (d3),
        .valid_in  (v3),
        .ack       (a3),
        .skip_idle (s3),
        .ready_in  (rdy3),
        .data_out  (do3),
        .valid_out (vo3),
        .ch_out    (co3)
`ifdef MUX_RR_PARITY_EN
        ,
        .parity_out(parity3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] din;
        logic [3:0]  vin;
        logic        skip;
        logic        rdy;
        logic [3:0]  ack;
        logic        vout;
        logic [3:0]  dout;
        logic [1:0]  ch;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(logic [15:0] din, logic [3:0] vin,
                                 logic skip, logic rdy, logic [3:0] a,
                                 logic vo, logic [3:0] d, logic [1:0] c);
        vec_t v;
        v.din  = din;
        v.vin  = vin;
        v.skip = skip;
        v.rdy  = rdy;
        v.ack  = a;
        v.vout = vo;
        v.dout = d;
        v.ch   = c;
        vecs.push_back(v);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // strict rotation, all lanes valid
        addv(16'hDCBA, 4'b1111, 0, 1, 4'b0001, 1, 4'hA, 2'd0);
        addv(16'hDCBA, 4'b1111, 0, 1, 4'b0010, 1, 4'hB, 2'd1);
        addv(16'hDCBA, 4'b1111, 0, 1, 4'b0100, 1, 4'hC, 2'd2);
        addv(16'hDCBA, 4'b1111, 0, 1, 4'b1000, 1, 4'hD, 2'd3);
        addv(16'hDCBA, 4'b1111, 0, 1, 4'b0001, 1, 4'hA, 2'd0);
        // strict, lane 2 idle -> empty slot
        addv(16'hDCBA, 4'b1011, 0, 1, 4'b0010, 1, 4'hB, 2'd1);
        addv(16'hDCBA, 4'b1011, 0, 1, 4'b0000, 0, 4'hC, 2'd2);
        addv(16'hDCBA, 4'b1011, 0, 1, 4'b1000, 1, 4'hD, 2'd3);
        addv(16'hDCBA, 4'b1011, 0, 1, 4'b0001, 1, 4'hA, 2'd0);
        // skip mode, lanes 1 and 3
        addv(16'hDCBA, 4'b1010, 1, 1, 4'b0010, 1, 4'hB, 2'd1);
        addv(16'hDCBA, 4'b1010, 1, 1, 4'b1000, 1, 4'hD, 2'd3);
        addv(16'hDCBA, 4'b1010, 1, 1, 4'b0010, 1, 4'hB, 2'd1);
        // skip mode, nothing valid: outputs and ptr hold
        addv(16'hDCBA, 4'b0000, 1, 1, 4'b0000, 0, 4'hB, 2'd1);
        addv(16'hDCBA, 4'b0000, 1, 1, 4'b0000, 0, 4'hB, 2'd1);
        // output empty, so ready_in=0 still advances; ptr was held at 2
        addv(16'hDCBA, 4'b1111, 1, 0, 4'b0100, 1, 4'hC, 2'd2);
        // backpressure with word 0x5
        addv(16'h5CBA, 4'b1111, 0, 1, 4'b1000, 1, 4'h5, 2'd3);
        addv(16'h5CBA, 4'b1111, 0, 0, 4'b0000, 1, 4'h5, 2'd3);
        addv(16'h5CBA, 4'b1111, 0, 0, 4'b0000, 1, 4'h5, 2'd3);
        addv(16'h5CBA, 4'b1111, 0, 0, 4'b0000, 1, 4'h5, 2'd3);
        addv(16'h5CBA, 4'b1111, 0, 1, 4'b0001, 1, 4'hA, 2'd0);

        reset     = 1'b1;
        data_in   = 16'hDCBA;
        valid_in  = 4'b1111;
        skip_idle = 1'b0;
        ready_in  = 1'b1;
        r3   = 1'b1;
        d3   = 12'h321;
        v3   = 3'b000;
        s3   = 1'b0;
        rdy3 = 1'b1;

        step;
        chk("rst_ack", 32'(ack), 32'h0);
        step;
        chk("rst_ack2", 32'(ack), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_vout", 32'(valid_out), 32'h0);
        chk("rst_ch", 32'(ch_out), 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            data_in   = vecs[i].din;
            valid_in  = vecs[i].vin;
            skip_idle = vecs[i].skip;
            ready_in  = vecs[i].rdy;
            #2;
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
            step;
            chk($sformatf("v%0d_vout", i), 32'(valid_out),
                32'(vecs[i].vout));
            chk($sformatf("v%0d_dout", i), 32'(data_out),
                32'(vecs[i].dout));
            chk($sformatf("v%0d_ch", i), 32'(ch_out), 32'(vecs[i].ch));
        end

        // reset during a stall discards the pending word
        data_in  = 16'hDCBA;
        valid_in = 4'b1111;
        ready_in = 1'b0;
        #2;
        chk("stall_ack", 32'(ack), 32'h0);
        step;
        chk("stall_vout", 32'(valid_out), 32'h1);
        reset = 1'b1;
        #2;
        chk("mrst_ack", 32'(ack), 32'h0);
        step;
        chk("mrst_vout", 32'(valid_out), 32'h0);
        chk("mrst_dout", 32'(data_out), 32'h0);
        reset    = 1'b0;
        ready_in = 1'b1;
        #2;
        chk("post_ack", 32'(ack), 32'h1);
        step;
        chk("post_ch", 32'(ch_out), 32'h0);
        chk("post_dout", 32'(data_out), 32'hA);
        step;
        chk("post_ch1", 32'(ch_out), 32'h1);

        // three-lane instance: strict wrap 0,1,2,0 then skip wrap
        v3 = 3'b111;
        step;
        r3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("n3_ack%0d", k), 32'(a3), 32'(1 << (k % 3)));
            step;
            chk($sformatf("n3_ch%0d", k), 32'(co3), 32'(k % 3));
            chk($sformatf("n3_d%0d", k), 32'(do3), 32'((k % 3) + 1));
        end
        s3 = 1'b1;
        v3 = 3'b001;
        #2;
        chk("n3_skip_ack", 32'(a3), 32'h1);
        step;
        chk("n3_skip_ch", 32'(co3), 32'h0);
        chk("n3_skip_v", 32'(vo3), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
